// File: rtl/val_repeat.sv
// rtl/val_repeat.sv - repeats one value per reference coordinate, stream by stream
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clk_en            clock enable; all state holds and no handshake completes when 0
//   flush             synchronous clear of FSM, hold, output register and err
//   tile_en           when 0 all ready/valid outputs are 0 and state holds
//   data_in*          value stream (one value per fiber, then DONE)
//   ref_in*           reference stream (coordinates, stop tokens, DONE)
//   data_out*         repeated value stream, 1-entry output register
//   err               sticky protocol-error flag
// Token: bit16=0 data (payload 15:0); bit16=1,bit8=1 DONE; bit16=1,bit8=0 stop Sn.
module val_repeat #(
  parameter int DATA_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  input  logic [DATA_W-1:0] ref_in,
  input  logic              ref_in_valid,
  output logic              ref_in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              err
);

  localparam logic [DATA_W-1:0] DONE_TOK = {1'b1, {(DATA_W-10){1'b0}}, 9'h100};

  typedef enum logic {LOAD, REPEAT} state_t;

  state_t            state;
  logic [DATA_W-2:0] hold;
  logic              out_vld_q;

  logic din_is_data, din_is_done, ref_is_data, ref_is_done;
  logic can_acc, en, din_rdy, ref_rdy, din_xfer, ref_xfer;

  assign din_is_data = ~data_in[DATA_W-1];
  assign din_is_done = data_in[DATA_W-1] & data_in[8];
  assign ref_is_data = ~ref_in[DATA_W-1];
  assign ref_is_done = ref_in[DATA_W-1] & ref_in[8];

  // Output register can take a token when empty or draining this cycle.
  assign can_acc = ~out_vld_q | data_out_ready;
  // Readies are suppressed in reset and flush so upstream never sees a lost handshake.
  assign en = rst_n & tile_en & ~flush;

  always_comb begin
    din_rdy = 1'b0;
    ref_rdy = 1'b0;
    case (state)
      LOAD: begin
        if (data_in_valid) begin
          if (din_is_done) begin
            // Every ref token in this case needs the output path free, so a
            // stalled sink also blocks the dropped-token path.
            if (ref_in_valid && can_acc) begin
              ref_rdy = 1'b1;
              din_rdy = ref_is_done;
            end
          end else begin
            // Data value, or a stray stop on the value stream (dropped, flagged).
            din_rdy = 1'b1;
          end
        end
      end
      REPEAT: ref_rdy = ref_in_valid & ~ref_is_done & can_acc;
      default: ;
    endcase
  end

  assign data_in_ready  = en & din_rdy;
  assign ref_in_ready   = en & ref_rdy;
  assign din_xfer       = data_in_ready & data_in_valid & clk_en;
  assign ref_xfer       = ref_in_ready & ref_in_valid & clk_en;
  assign data_out_valid = out_vld_q & tile_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      hold      <= '0;
      data_out  <= '0;
      out_vld_q <= 1'b0;
      err       <= 1'b0;
    end else if (flush) begin
      state     <= LOAD;
      hold      <= '0;
      data_out  <= '0;
      out_vld_q <= 1'b0;
      err       <= 1'b0;
    end else if (clk_en && tile_en) begin
      if (out_vld_q && data_out_ready) out_vld_q <= 1'b0;
      case (state)
        LOAD: begin
          if (din_xfer) begin
            if (din_is_data) begin
              hold  <= data_in[DATA_W-2:0];
              state <= REPEAT;
            end else if (!din_is_done) begin
              err <= 1'b1;
            end
          end
          if (ref_xfer) begin
            if (ref_is_done) begin
              data_out  <= DONE_TOK;
              out_vld_q <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        REPEAT: begin
          if (ref_xfer) begin
            out_vld_q <= 1'b1;
            if (ref_is_data) begin
              data_out <= {1'b0, hold};
            end else begin
              data_out <= ref_in;
              state    <= LOAD;
            end
          end else if (ref_in_valid && ref_is_done) begin
            // DONE inside a fiber: leave it at the head so LOAD can pair it.
            err   <= 1'b1;
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_val_repeat.sv
// tb/tb_val_repeat.sv - directed self-checking bench for val_repeat
module tb_val_repeat;

  localparam logic [16:0] DONE = 17'h10100;
  localparam logic [16:0] S0   = 17'h10000;
  localparam logic [16:0] S1   = 17'h10001;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, flush, tile_en;
  logic [16:0] data_in, ref_in, data_out;
  logic        data_in_valid, data_in_ready, ref_in_valid, ref_in_ready;
  logic        data_out_valid, data_out_ready, err;

  int nvec = 0;
  int nerr = 0;

  logic [16:0] dq[$];
  logic [16:0] rq[$];
  logic [16:0] exp_q[$];
  logic [16:0] out_q[$];
  int stall_viol, bp_viol, timed_out;

  val_repeat #(.DATA_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .ref_in(ref_in), .ref_in_valid(ref_in_valid), .ref_in_ready(ref_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  // Drives dq/rq as sources and collects exp_n output tokens into out_q.
  task automatic run_stream(input bit rand_mode, input int exp_n);
    int di = 0;
    int ri = 0;
    int cyc = 0;
    bit d_fire, r_fire, o_fire, prev_stall;
    logic [16:0] prev_data;
    prev_stall = 0;
    prev_data  = '0;
    out_q.delete();
    stall_viol = 0;
    bp_viol    = 0;
    timed_out  = 0;
    while (out_q.size() < exp_n) begin
      if (cyc >= 600) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
      data_in_valid = (di < dq.size());
      data_in       = data_in_valid ? dq[di] : '0;
      ref_in_valid  = (ri < rq.size());
      ref_in        = ref_in_valid ? rq[ri] : '0;
      if (rand_mode) begin
        data_out_ready = 1'($urandom_range(0, 1));
        clk_en         = ($urandom_range(0, 3) != 0);
      end else begin
        data_out_ready = 1'b1;
        clk_en         = 1'b1;
      end
      #1;
      if (prev_stall && (data_out_valid !== 1'b1 || data_out !== prev_data)) stall_viol++;
      if (data_out_valid && !data_out_ready && ref_in_ready) bp_viol++;
      d_fire = data_in_valid && data_in_ready && clk_en;
      r_fire = ref_in_valid && ref_in_ready && clk_en;
      o_fire = data_out_valid && data_out_ready && clk_en;
      if (o_fire) out_q.push_back(data_out);
      prev_stall = data_out_valid && !o_fire;
      prev_data  = data_out;
      @(posedge clk);
      if (d_fire) di++;
      if (r_fire) ri++;
      cyc++;
    end
    @(negedge clk);
    data_in_valid  = 1'b0;
    ref_in_valid   = 1'b0;
    data_in        = '0;
    ref_in         = '0;
    data_out_ready = 1'b1;
    clk_en         = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
    data_out_ready = 1'b1;
    data_in = 17'h00005; data_in_valid = 1'b1;
    ref_in  = 17'h00000; ref_in_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (data_out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", data_out_valid); end
    nvec++; if (data_out !== 17'h0) begin nerr++; $display("FAIL reset_data got %h want 0", data_out); end
    nvec++; if (data_in_ready !== 1'b0) begin nerr++; $display("FAIL reset_din_ready got %b want 0", data_in_ready); end
    nvec++; if (ref_in_ready !== 1'b0) begin nerr++; $display("FAIL reset_ref_ready got %b want 0", ref_in_ready); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL reset_err got %b want 0", err); end
    @(negedge clk);
    data_in_valid = 1'b0; ref_in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    dq = '{17'h00005, DONE};
    rq = '{17'h00000, 17'h00001, 17'h00002, S0, DONE};
    exp_q = '{17'h00005, 17'h00005, 17'h00005, S0, DONE};
    run_stream(0, exp_q.size());
    nvec++; if (timed_out != 0) begin nerr++; $display("FAIL basic_timeout got %0d outputs want %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      nvec++;
      if (out_q[i] !== exp_q[i]) begin nerr++; $display("FAIL basic_out[%0d] got %h want %h", i, out_q[i], exp_q[i]); end
    end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL basic_err got %b want 0", err); end
  endtask

  task automatic test_empty_fiber();
    dq = '{17'h00007, 17'h00009, DONE};
    rq = '{S0, 17'h00000, S1, DONE};
    exp_q = '{S0, 17'h00009, S1, DONE};
    run_stream(0, exp_q.size());
    nvec++; if (timed_out != 0) begin nerr++; $display("FAIL empty_timeout got %0d outputs want %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      nvec++;
      if (out_q[i] !== exp_q[i]) begin nerr++; $display("FAIL empty_out[%0d] got %h want %h", i, out_q[i], exp_q[i]); end
    end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL empty_err got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    dq = '{17'h00005, DONE};
    rq = '{17'h00000, 17'h00001, 17'h00002, S0, DONE};
    exp_q = '{17'h00005, 17'h00005, 17'h00005, S0, DONE};
    run_stream(1, exp_q.size());
    nvec++; if (timed_out != 0) begin nerr++; $display("FAIL bp_timeout got %0d outputs want %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      nvec++;
      if (out_q[i] !== exp_q[i]) begin nerr++; $display("FAIL bp_out[%0d] got %h want %h", i, out_q[i], exp_q[i]); end
    end
    nvec++; if (stall_viol != 0) begin nerr++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_viol); end
    nvec++; if (bp_viol != 0) begin nerr++; $display("FAIL bp_ref_ready got %0d ready-while-full want 0", bp_viol); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL bp_err got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    dq = '{17'h00005, DONE};
    rq = '{17'h00000, 17'h00001, 17'h00002, S0, DONE};
    run_stream(0, 2);
    data_in = 17'h00005; data_in_valid = 1'b1;
    ref_in  = 17'h00001; ref_in_valid  = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    nvec++; if (data_out_valid !== 1'b0) begin nerr++; $display("FAIL rmid_valid got %b want 0", data_out_valid); end
    nvec++; if (data_out !== 17'h0) begin nerr++; $display("FAIL rmid_data got %h want 0", data_out); end
    nvec++; if (data_in_ready !== 1'b0) begin nerr++; $display("FAIL rmid_din_ready got %b want 0", data_in_ready); end
    nvec++; if (ref_in_ready !== 1'b0) begin nerr++; $display("FAIL rmid_ref_ready got %b want 0", ref_in_ready); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rmid_err got %b want 0", err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    data_in_valid = 1'b0; ref_in_valid = 1'b0;
    rst_n = 1'b1;
    exp_q = '{17'h00005, 17'h00005, 17'h00005, S0, DONE};
    run_stream(0, exp_q.size());
    nvec++; if (timed_out != 0) begin nerr++; $display("FAIL rmid_timeout got %0d outputs want %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      nvec++;
      if (out_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rmid_out[%0d] got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_tile_en();
    @(negedge clk);
    tile_en = 1'b0;
    data_in = 17'h00005; data_in_valid = 1'b1;
    ref_in  = 17'h00000; ref_in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      nvec++; if (data_in_ready !== 1'b0) begin nerr++; $display("FAIL tile_din_ready[%0d] got %b want 0", i, data_in_ready); end
      nvec++; if (ref_in_ready !== 1'b0) begin nerr++; $display("FAIL tile_ref_ready[%0d] got %b want 0", i, ref_in_ready); end
      nvec++; if (data_out_valid !== 1'b0) begin nerr++; $display("FAIL tile_valid[%0d] got %b want 0", i, data_out_valid); end
    end
    @(negedge clk);
    tile_en = 1'b1;
    data_in_valid = 1'b0; ref_in_valid = 1'b0;
  endtask

  task automatic test_err_ref_drop();
    dq = '{DONE};
    rq = '{17'h00000, DONE};
    exp_q = '{DONE};
    run_stream(0, exp_q.size());
    nvec++; if (timed_out != 0) begin nerr++; $display("FAIL drop_timeout got %0d outputs want %0d", out_q.size(), exp_q.size()); end
    nvec++; if (out_q[0] !== DONE) begin nerr++; $display("FAIL drop_out got %h want %h", out_q[0], DONE); end
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL drop_err got %b want 1", err); end
  endtask

  task automatic test_flush();
    dq = '{17'h00005, DONE};
    rq = '{17'h00000, 17'h00001, 17'h00002, S0, DONE};
    run_stream(0, 1);
    flush = 1'b1; clk_en = 1'b0; data_out_ready = 1'b0;
    @(posedge clk);
    #1;
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL flush_err got %b want 0", err); end
    nvec++; if (data_out_valid !== 1'b0) begin nerr++; $display("FAIL flush_valid got %b want 0", data_out_valid); end
    nvec++; if (data_out !== 17'h0) begin nerr++; $display("FAIL flush_data got %h want 0", data_out); end
    @(negedge clk);
    flush = 1'b0; clk_en = 1'b1; data_out_ready = 1'b1;
    dq = '{17'h00007, 17'h00009, DONE};
    rq = '{S0, 17'h00000, S1, DONE};
    exp_q = '{S0, 17'h00009, S1, DONE};
    run_stream(0, exp_q.size());
    nvec++; if (timed_out != 0) begin nerr++; $display("FAIL flush_timeout got %0d outputs want %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      nvec++;
      if (out_q[i] !== exp_q[i]) begin nerr++; $display("FAIL flush_out[%0d] got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_err_repeat_done();
    dq = '{17'h00005, DONE};
    rq = '{17'h00000, DONE};
    exp_q = '{17'h00005, DONE};
    run_stream(0, exp_q.size());
    nvec++; if (timed_out != 0) begin nerr++; $display("FAIL rdone_timeout got %0d outputs want %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      nvec++;
      if (out_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rdone_out[%0d] got %h want %h", i, out_q[i], exp_q[i]); end
    end
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL rdone_err got %b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_fiber();
    test_backpressure();
    test_reset_mid();
    test_tile_en();
    test_err_ref_drop();
    test_flush();
    test_err_repeat_done();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/val_repeat.md
VAL_REPEAT -- requirements
Module: val_repeat

Interface
REQ-001 SHALL have parameter DATA_W, default 17, meaning stream token width: bit 16 = control flag, bits 15:0 = payload.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port clk_en, input, 1, clock enable; when 0, all state holds and no handshake completes.
REQ-005 SHALL have port flush, input, 1, synchronous clear of FSM, output register and err.
REQ-006 SHALL have port tile_en, input, 1, when 0, all ready and valid outputs are 0 and state holds.
REQ-007 SHALL have port data_in, input, 17, the value stream: one value per fiber, then DONE.
REQ-008 SHALL have ports data_in_valid (input, 1) and data_in_ready (output, 1), the value-stream handshake.
REQ-009 SHALL have port ref_in, input, 17, the reference stream: coordinates, stop tokens and DONE.
REQ-010 SHALL have ports ref_in_valid (input, 1) and ref_in_ready (output, 1), the reference-stream handshake.
REQ-011 SHALL have port data_out, output, 17, the repeated value stream.
REQ-012 SHALL have ports data_out_valid (output, 1) and data_out_ready (input, 1), the output handshake.
REQ-013 SHALL have port err, output, 1, sticky protocol-error flag.

Function
REQ-014 Token decode SHALL be: bit16=0 data; bit16=1 and bit8=1 DONE (canonical 17'h10100); bit16=1 and bit8=0 stop Sn, with n = bits 7:0.
REQ-015 A transfer SHALL occur only on a clock edge where valid=1, ready=1, clk_en=1 and tile_en=1.
REQ-016 The FSM SHALL have states LOAD and REPEAT; reset and flush SHALL enter LOAD.
REQ-017 The output SHALL be a 1-entry register; it may accept a new token when empty or when data_out_ready=1 in the same cycle.
REQ-018 Latency SHALL be exactly 1 cycle from the ref_in transfer to the matching data_out_valid.
REQ-019 In LOAD with a data token at the data_in head:
- SHALL assert data_in_ready;
- on transfer, SHALL store the payload in the hold register and go to REPEAT;
- ref_in_ready SHALL be 0.
REQ-020 In REPEAT with a data token at the ref_in head:
- SHALL assert ref_in_ready when the output can accept;
- SHALL emit {1'b0, hold}, one output per ref coordinate;
- SHALL stay in REPEAT.
REQ-021 In REPEAT with stop Sn at the ref_in head:
- SHALL consume it and emit Sn unchanged;
- SHALL return to LOAD, so the next value is fetched.
REQ-022 An empty fiber (ref stop arriving immediately after LOAD) SHALL still consume exactly one data_in value: LOAD accepts the value, then REPEAT emits only the stop.
REQ-023 In LOAD with DONE at both the data_in and ref_in heads:
- SHALL consume both in the same cycle;
- SHALL emit 17'h10100 and remain in LOAD.
REQ-024 In LOAD with DONE at the data_in head and a non-DONE token at the ref_in head:
- SHALL consume and drop the ref token;
- SHALL set err;
- SHALL not consume data_in.
REQ-025 In REPEAT with DONE at the ref_in head:
- SHALL set err;
- SHALL go to LOAD without consuming ref_in.
REQ-026 data_in_ready and ref_in_ready SHALL never both be 1, except in the REQ-023 DONE case.
REQ-027 Under output backpressure (data_out_ready=0 with the output register full):
- ref_in_ready SHALL be 0;
- data_out and data_out_valid SHALL hold stable until transfer.
REQ-028 err SHALL be sticky until reset or flush.

Reset
REQ-029 While rst_n=0, SHALL force: FSM=LOAD, hold=0, data_out=0, data_out_valid=0, data_in_ready=0, ref_in_ready=0, err=0.
REQ-030 Reset deassertion mid-stream SHALL restart in LOAD; no partial token SHALL be emitted.
REQ-031 flush=1 SHALL apply the same values as REQ-029 at the next clock edge, regardless of clk_en.

Verification
REQ-032 data_in=5,DONE; ref_in=c0,c1,c2,S0,DONE; sink always ready -> out=5,5,5,S0,DONE; err=0.
REQ-033 data_in=7,9,DONE; ref_in=S0,c0,S1,DONE -> out=S0,9,S1,DONE; value 7 is discarded (empty fiber).
REQ-034 Same stimulus as REQ-032 with data_out_ready toggling at random -> identical sequence; valid and data stable while stalled.
REQ-035 ref_in=c0,DONE against data_in=DONE -> c0 dropped, err=1, then DONE emitted.
REQ-036 Assert rst_n=0 during the second repeat of REQ-032, then restart the stream -> all outputs 0 during reset; the full expected sequence follows after restart.
REQ-037 tile_en=0 with both inputs valid -> both readies 0 and data_out_valid=0 for 10 cycles.
